pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game-sequencing controller for the pong display pipeline. It owns both player scores and drives them as the two BCD digits consumed by the score-text overlay. It also selects which text overlay is active and holds or releases the ball graphics. A Moore state machine steps through new-game, play, new-ball and game-over phases, paced by a frame-tick timer and a start button.

## Interface

Parameters:
- WIN_SCORE, default 5: score that ends the game; legal range 1..9.
- TIMER_TICKS, default 120: pause length in frames (about 2 s at 60 Hz); legal range 1..255.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- refr_tick  in  1  one-cycle pulse once per video frame.
- btn_start  in  1  start/serve button, level, already debounced.
- p1_miss  in  1  one-cycle pulse: ball passed player-1 paddle.
- p2_miss  in  1  one-cycle pulse: ball passed player-2 paddle.
- dig1  out  4  player-1 score, BCD 0..9.
- dig0  out  4  player-2 score, BCD 0..9.
- text_sel  out  2  overlay select: 00 score only, 01 score + "press start" rule text, 10 score + "game over".
- gra_still  out  1  1 freezes the ball at the serve position.
- serve_dir  out  1  0 serves toward player 1, 1 serves toward player 2.
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw.

## Operation

- States: NEWGAME, PLAY, NEWBALL, OVER. State is registered; all outputs except dig0/dig1/winner/serve_dir decode from state only (Moore).
- Output decode per state:
  - NEWGAME: text_sel=01, gra_still=1.
  - PLAY: text_sel=00, gra_still=0.
  - NEWBALL: text_sel=01, gra_still=1.
  - OVER: text_sel=10, gra_still=1.
- Start edge: btn_q registers btn_start. press = btn_start & ~btn_q. btn_q resets to 1, so a button held through reset never triggers.
- Timer: 8-bit down-counter. It loads TIMER_TICKS on entry to NEWBALL or OVER and decrements on each refr_tick while nonzero. timer_done = (timer == 0).
- NEWGAME: press -> PLAY.
- PLAY, miss handling:
  - p1_miss increments dig0 (player 2 scores) and sets serve_dir=0.
  - p2_miss increments dig1 (player 1 scores) and sets serve_dir=1.
  - Both in the same cycle: both scores increment; serve_dir is unchanged.
  - If any incremented score equals WIN_SCORE -> OVER, and winner is set: 01 if dig1 hit it, 10 if dig0 hit it, 11 if both did.
  - Otherwise any miss -> NEWBALL.
- NEWBALL: press while timer_done -> PLAY. A press before timer_done is discarded; the button must be pressed again.
- OVER: timer_done -> NEWGAME. On this transition both scores clear to 0, winner clears to 00 and serve_dir clears to 0.
- Misses outside PLAY are ignored. Scores never exceed WIN_SCORE, so no BCD wrap exists.
- Reset (any cycle, mid-game included): state=NEWGAME, dig0=dig1=0, timer=0, winner=00, serve_dir=0, btn_q=1. Outputs are therefore text_sel=01, gra_still=1.

## Timing

- Miss pulse at cycle N: score, serve_dir, winner and state all update at edge N+1. text_sel/gra_still reflect the new state from N+1.
- Button rising at cycle N (btn_q=0): transition at edge N+1.
- Timer loads at the transition edge. Exactly TIMER_TICKS refr_ticks after entry, timer_done asserts on the cycle after the final tick's edge.
- OVER -> NEWGAME occurs the cycle after timer_done first reads 1.
- refr_tick coinciding with the state-entry edge does not decrement; the load wins.
- Reset has priority over every input in the same cycle.

## Test plan

- Reset with btn_start held high, then release and press again -> state stays NEWGAME (text_sel=01) until the new press; PLAY (gra_still=0) one cycle after the press edge.
- In PLAY, one p1_miss pulse -> next cycle dig0=1, dig1=0, serve_dir=0, text_sel=01, gra_still=1.
- In NEWBALL with TIMER_TICKS=3: press after 1 tick -> stays NEWBALL; press after 3 ticks -> PLAY.
- Drive p2_miss five times (WIN_SCORE=5) with serves between -> after the fifth: dig1=5, winner=01, text_sel=10. After 3 refr_ticks (TIMER_TICKS=3) -> NEWGAME with dig0=dig1=0, winner=00.
- With dig0=dig1=4, assert p1_miss and p2_miss together -> dig0=dig1=5, winner=11, state OVER.
- Assert reset in OVER mid-countdown -> next cycle all outputs equal reset values; a miss pulse in NEWGAME leaves the scores at 0.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Game-sequencing controller for pong: owns both BCD scores, overlay select,
// ball hold and serve direction, stepping NEWGAME/PLAY/NEWBALL/OVER phases.
module pong_game_ctrl #(
  parameter int WIN_SCORE   = 5,
  parameter int TIMER_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic       btn_start,
  input  logic       p1_miss,
  input  logic       p2_miss,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [1:0] text_sel,
  output logic       gra_still,
  output logic       serve_dir,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {NEWGAME, PLAY, NEWBALL, OVER} state_t;

  localparam logic [3:0] WIN_BCD    = 4'(WIN_SCORE);
  localparam logic [7:0] TIMER_LOAD = 8'(TIMER_TICKS);

  state_t     state_reg, state_next;
  logic [7:0] timer_reg, timer_next;
  logic [3:0] dig0_reg, dig0_next;
  logic [3:0] dig1_reg, dig1_next;
  logic [1:0] winner_reg, winner_next;
  logic       serve_dir_reg, serve_dir_next;
  logic       btn_q_reg;

  logic press;
  logic timer_done;
  logic hit0, hit1;
  logic timer_load;

  assign press      = btn_start & ~btn_q_reg;
  assign timer_done = (timer_reg == 8'd0);
  assign hit0       = p1_miss && ((dig0_reg + 4'd1) == WIN_BCD);
  assign hit1       = p2_miss && ((dig1_reg + 4'd1) == WIN_BCD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= NEWGAME;
      timer_reg     <= 8'd0;
      dig0_reg      <= 4'd0;
      dig1_reg      <= 4'd0;
      winner_reg    <= 2'b00;
      serve_dir_reg <= 1'b0;
      btn_q_reg     <= 1'b1;  // a button held through reset must not count as a press
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      dig0_reg      <= dig0_next;
      dig1_reg      <= dig1_next;
      winner_reg    <= winner_next;
      serve_dir_reg <= serve_dir_next;
      btn_q_reg     <= btn_start;
    end
  end

  always_comb begin
    state_next     = state_reg;
    dig0_next      = dig0_reg;
    dig1_next      = dig1_reg;
    winner_next    = winner_reg;
    serve_dir_next = serve_dir_reg;
    timer_load     = 1'b0;
    text_sel       = 2'b01;
    gra_still      = 1'b1;

    case (state_reg)
      NEWGAME: begin
        if (press) state_next = PLAY;
      end
      PLAY: begin
        text_sel  = 2'b00;
        gra_still = 1'b0;
        if (p1_miss || p2_miss) begin
          if (p1_miss) dig0_next = dig0_reg + 4'd1;
          if (p2_miss) dig1_next = dig1_reg + 4'd1;
          // a simultaneous double miss leaves the serve side where it was
          if (p1_miss && !p2_miss) serve_dir_next = 1'b0;
          if (p2_miss && !p1_miss) serve_dir_next = 1'b1;
          if (hit0 || hit1) begin
            state_next  = OVER;
            winner_next = {hit0, hit1};
          end else begin
            state_next = NEWBALL;
          end
          timer_load = 1'b1;
        end
      end
      NEWBALL: begin
        if (press && timer_done) state_next = PLAY;
      end
      OVER: begin
        text_sel = 2'b10;
        if (timer_done) begin
          state_next     = NEWGAME;
          dig0_next      = 4'd0;
          dig1_next      = 4'd0;
          winner_next    = 2'b00;
          serve_dir_next = 1'b0;
        end
      end
      default: state_next = NEWGAME;
    endcase
  end

  // Load on phase entry beats a coincident frame tick.
  always_comb begin
    timer_next = timer_reg;
    if (timer_load)
      timer_next = TIMER_LOAD;
    else if (refr_tick && !timer_done)
      timer_next = timer_reg - 8'd1;
  end

  assign dig0      = dig0_reg;
  assign dig1      = dig1_reg;
  assign winner    = winner_reg;
  assign serve_dir = serve_dir_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed scenarios plus randomized
// stimulus compared against a phase-level reference model.
module tb_pong_game_ctrl;

  localparam int W = 5;
  localparam int T = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refr_tick = 1'b0;
  logic       btn_start = 1'b1;
  logic       p1_miss = 1'b0;
  logic       p2_miss = 1'b0;
  logic [3:0] dig1, dig0;
  logic [1:0] text_sel;
  logic       gra_still;
  logic       serve_dir;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 newgame, 1 play, 2 newball, 3 over.
  int m_phase = 0, m_s1 = 0, m_s2 = 0, m_serve = 0, m_win = 0;
  int m_ticks = T;
  int m_btn_prev = 1;

  pong_game_ctrl #(.WIN_SCORE(W), .TIMER_TICKS(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .refr_tick (refr_tick),
    .btn_start (btn_start),
    .p1_miss   (p1_miss),
    .p2_miss   (p2_miss),
    .dig1      (dig1),
    .dig0      (dig0),
    .text_sel  (text_sel),
    .gra_still (gra_still),
    .serve_dir (serve_dir),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit press, done, entered;
    if (reset) begin
      m_phase = 0; m_s1 = 0; m_s2 = 0; m_serve = 0; m_win = 0;
      m_ticks = T; m_btn_prev = 1;
      return;
    end
    press   = btn_start && (m_btn_prev == 0);
    m_btn_prev = int'(btn_start);
    done    = (m_ticks >= T);
    entered = 0;
    case (m_phase)
      0: if (press) m_phase = 1;
      1: if (p1_miss || p2_miss) begin
           if (p1_miss) m_s2++;
           if (p2_miss) m_s1++;
           if (p1_miss && !p2_miss) m_serve = 0;
           if (p2_miss && !p1_miss) m_serve = 1;
           if (m_s1 == W || m_s2 == W) begin
             m_win = (m_s1 == W ? 1 : 0) + (m_s2 == W ? 2 : 0);
             m_phase = 3;
           end else begin
             m_phase = 2;
           end
           entered = 1;
         end
      2: if (press && done) m_phase = 1;
      default: if (done) begin
           m_phase = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_serve = 0;
         end
    endcase
    if (entered) m_ticks = 0;
    else if (refr_tick && m_ticks < T) m_ticks++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic serve();
    btn_start = 1'b0;
    refr_tick = 1'b1;
    repeat (T) cycle();
    refr_tick = 1'b0;
    btn_start = 1'b1;
    cycle();
    btn_start = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_start = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    repeat (3) cycle();
    checks++; if (text_sel !== 2'b01) begin errors++; $display("FAIL reset_text_sel: got %0d expected 1", text_sel); end
    checks++; if (gra_still !== 1'b1) begin errors++; $display("FAIL reset_gra_still: got %0d expected 1", gra_still); end
    checks++; if ({dig1, dig0} !== 8'h00) begin errors++; $display("FAIL reset_scores: got %h expected 00", {dig1, dig0}); end
    checks++; if ({winner, serve_dir} !== 3'b000) begin errors++; $display("FAIL reset_winner_serve: got %b expected 000", {winner, serve_dir}); end
    btn_start = 1'b0;
    cycle();
    checks++; if (text_sel !== 2'b01) begin errors++; $display("FAIL held_btn_no_start: got %0d expected 1", text_sel); end
    btn_start = 1'b1;
    cycle();
    checks++; if ({text_sel, gra_still} !== 3'b000) begin errors++; $display("FAIL press_to_play: got %b expected 000", {text_sel, gra_still}); end
    $display("test_reset: text_sel=%0d gra_still=%0d", text_sel, gra_still);
  endtask

  task automatic test_miss();
    btn_start = 1'b0; p1_miss = 1'b1;
    cycle();
    p1_miss = 1'b0;
    checks++; if ({dig1, dig0} !== 8'h01) begin errors++; $display("FAIL p1_miss_scores: got %h expected 01", {dig1, dig0}); end
    checks++; if (serve_dir !== 1'b0) begin errors++; $display("FAIL p1_miss_serve: got %0d expected 0", serve_dir); end
    checks++; if ({text_sel, gra_still} !== 3'b011) begin errors++; $display("FAIL p1_miss_newball: got %b expected 011", {text_sel, gra_still}); end
    $display("test_miss: dig1=%0d dig0=%0d", dig1, dig0);
  endtask

  task automatic test_newball_timer();
    refr_tick = 1'b1;
    cycle();
    refr_tick = 1'b0; btn_start = 1'b1;
    cycle();
    btn_start = 1'b0;
    checks++; if (gra_still !== 1'b1) begin errors++; $display("FAIL early_press_ignored: got gra_still=%0d expected 1", gra_still); end
    refr_tick = 1'b1;
    repeat (2) cycle();
    refr_tick = 1'b0;
    checks++; if (text_sel !== 2'b01) begin errors++; $display("FAIL newball_wait: got %0d expected 1", text_sel); end
    btn_start = 1'b1;
    cycle();
    btn_start = 1'b0;
    checks++; if ({text_sel, gra_still} !== 3'b000) begin errors++; $display("FAIL timed_press_play: got %b expected 000", {text_sel, gra_still}); end
    $display("test_newball_timer: text_sel=%0d", text_sel);
  endtask

  task automatic test_p2_win();
    for (int i = 0; i < W; i++) begin
      p2_miss = 1'b1;
      cycle();
      p2_miss = 1'b0;
      checks++; if (dig1 !== 4'(i + 1)) begin errors++; $display("FAIL p2_score_%0d: got %0d expected %0d", i, dig1, i + 1); end
      if (i < W - 1) begin
        checks++; if ({text_sel, serve_dir} !== 3'b011) begin errors++; $display("FAIL p2_serve_%0d: got %b expected 011", i, {text_sel, serve_dir}); end
        serve();
      end
    end
    checks++; if ({winner, text_sel} !== 4'b0110) begin errors++; $display("FAIL p1_wins: got %b expected 0110", {winner, text_sel}); end
    refr_tick = 1'b1;
    repeat (T) cycle();
    refr_tick = 1'b0;
    checks++; if (text_sel !== 2'b10) begin errors++; $display("FAIL over_hold: got %0d expected 2", text_sel); end
    cycle();
    checks++; if ({text_sel, winner, dig1, dig0} !== 12'b01_00_0000_0000) begin errors++; $display("FAIL over_to_newgame: got %h expected 400", {text_sel, winner, dig1, dig0}); end
    $display("test_p2_win: text_sel=%0d winner=%0d", text_sel, winner);
  endtask

  task automatic test_draw();
    btn_start = 1'b1;
    cycle();
    btn_start = 1'b0;
    for (int i = 0; i < W; i++) begin
      p1_miss = 1'b1; p2_miss = 1'b1;
      cycle();
      p1_miss = 1'b0; p2_miss = 1'b0;
      if (i < W - 1) serve();
    end
    checks++; if ({dig1, dig0} !== 8'h55) begin errors++; $display("FAIL draw_scores: got %h expected 55", {dig1, dig0}); end
    checks++; if ({winner, text_sel, serve_dir} !== 5'b11_10_0) begin errors++; $display("FAIL draw_winner: got %b expected 11100", {winner, text_sel, serve_dir}); end
    $display("test_draw: winner=%0d", winner);
  endtask

  task automatic test_reset_mid();
    refr_tick = 1'b1;
    cycle();
    refr_tick = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++; if ({dig1, dig0, text_sel, gra_still, serve_dir, winner} !== 14'b0000_0000_01_1_0_00) begin errors++; $display("FAIL reset_mid_outputs: got %b expected 00000000011000", {dig1, dig0, text_sel, gra_still, serve_dir, winner}); end
    p1_miss = 1'b1;
    cycle();
    p1_miss = 1'b0;
    checks++; if ({dig1, dig0, text_sel} !== 10'b0000_0000_01) begin errors++; $display("FAIL newgame_miss_ignored: got %b expected 0000000001", {dig1, dig0, text_sel}); end
    $display("test_reset_mid: dig0=%0d text_sel=%0d", dig0, text_sel);
  endtask

  task automatic test_random();
    logic [13:0] exp_v, got_v;
    int tsel;
    for (int n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      refr_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) btn_start = ~btn_start;
      p1_miss   = ($urandom_range(0, 9) == 0);
      p2_miss   = ($urandom_range(0, 9) == 0);
      cycle();
      tsel  = (m_phase == 3) ? 2 : (m_phase == 1 ? 0 : 1);
      exp_v = {4'(m_s1), 4'(m_s2), 2'(tsel), (m_phase != 1), 1'(m_serve), 2'(m_win)};
      got_v = {dig1, dig0, text_sel, gra_still, serve_dir, winner};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %b expected %b", n, got_v, exp_v);
      end
    end
    reset = 1'b0; refr_tick = 1'b0; p1_miss = 1'b0; p2_miss = 1'b0;
    $display("test_random: 4000 cycles compared");
  endtask

  initial begin
    test_reset();
    test_miss();
    test_newball_timer();
    test_p2_win();
    test_draw();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
